uart_frame_sched: RTL and testbench

//  Round-robin scheduler sharing one 64-bit UART frame transmitter among N_CH filter-output channels.

---
 rtl/uart_sched_pkg.sv | 25 ++
 rtl/uart_frame_sched_if.sv | 29 ++
 rtl/uart_frame_sched_rr_arbiter.sv | 36 +++
 rtl/uart_frame_sched.sv | 167 ++++++++++++++++
 tb/tb_uart_frame_sched.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART frame scheduler.
//   DATA_W         sample width carried end to end (signed)
//   sched_state_e  scheduler FSM encoding
//   frame_cycles() sys_clk cycles per frame including the inter-frame gap
//   cnt_width()    width of a down-counter able to hold frame_cycles()
package uart_sched_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } sched_state_e;

  function automatic int frame_cycles(input int clk_freq, input int uart_bps,
                                      input int frame_bits, input int gap_cycles);
    return (clk_freq / uart_bps) * frame_bits + gap_cycles;
  endfunction

  function automatic int cnt_width(input int fc);
    return $clog2(fc + 1);
  endfunction

endpackage

// File: rtl/uart_frame_sched_if.sv
// Channel-input / transmitter-output bundle of the UART frame scheduler.
//   ch_data   N_CH*64  channel k sample at [64k+63:64k], signed
//   ch_valid  N_CH     one-cycle sample strobe per channel
//   tx_data   64       sample presented to the transmitter, signed
//   tx_flag   1        one-cycle frame start pulse
//   tx_ch     3        channel index of the current frame
// Modports: slave = scheduler side, master = channel sources / transmitter side.
interface uart_frame_sched_if #(
  parameter int N_CH = 4
);
  import uart_sched_pkg::*;

  logic [N_CH*DATA_W-1:0]    ch_data;
  logic [N_CH-1:0]           ch_valid;
  logic signed [DATA_W-1:0]  tx_data;
  logic                      tx_flag;
  logic [2:0]                tx_ch;

  modport slave (
    input  ch_data, ch_valid,
    output tx_data, tx_flag, tx_ch
  );

  modport master (
    output ch_data, ch_valid,
    input  tx_data, tx_flag, tx_ch
  );

endinterface

// File: rtl/uart_frame_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req      N_CH     pending requests
//   ptr      IDX_W    last granted index; search starts at ptr+1 and wraps
//   gnt_idx  IDX_W    first pending index after ptr (0 when nothing pending)
//   any      1        at least one request pending
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]          req,
  input  logic [$clog2(N_CH)-1:0]  ptr,
  output logic [$clog2(N_CH)-1:0]  gnt_idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_CH);

  int               pos;
  logic [IDX_W-1:0] idx;

  assign any = |req;

  // Walk from the farthest candidate back toward ptr+1 so the nearest
  // pending index is the last one written and therefore wins.
  always_comb begin
    gnt_idx = '0;
    pos     = 0;
    idx     = '0;
    for (int i = N_CH; i >= 1; i--) begin
      pos = int'(ptr) + i;
      if (pos >= N_CH) pos = pos - N_CH;
      idx = IDX_W'(pos);
      if (req[idx]) gnt_idx = idx;
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin scheduler sharing one 64-bit UART frame transmitter among N_CH
// channels. Each channel owns a one-entry holding slot; one pending slot at a
// time is granted, started with a one-cycle tx_flag, and its data held stable
// while a counter times the frame plus gap (the transmitter has no ready).
//
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        uart_frame_sched_if.slave: ch_data/ch_valid in, tx_data/tx_flag/tx_ch out
//   ovf_clr    clears all ovf_flag bits (a same-cycle new overflow wins)
//   busy       high from LOAD through the end of WAIT
//   ovf_flag   sticky per channel: a sample arrived while its slot was pending
//
// Build option: define UART_SCHED_OVERWRITE_EN to let an overflowing sample
// replace the pending slot data (newest wins). Default keeps the pending data
// and drops the overflowing sample (oldest wins).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no frame in flight; grant the next pending slot if any
// S_LOAD | tx_flag pulse, frame data/channel presented (one cycle)
// S_WAIT | frame + gap timer counting down; outputs held
module uart_frame_sched
  import uart_sched_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int FRAME_BITS = 90,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  uart_frame_sched_if.slave    bus,
  input  logic                 ovf_clr,
  output logic                 busy,
  output logic [N_CH-1:0]      ovf_flag
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS, FRAME_BITS, GAP_CYCLES);
  localparam int CNT_W        = cnt_width(FRAME_CYCLES);
  localparam int IDX_W        = $clog2(N_CH);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(N_CH - 1);

`ifdef UART_SCHED_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  sched_state_e              state_q;
  logic [IDX_W-1:0]          rr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic signed [DATA_W-1:0]  tx_data_q;
  logic                      tx_flag_q;
  logic [2:0]                tx_ch_q;
  logic                      busy_q;

  logic [N_CH-1:0]           pend_vec;
  logic [N_CH-1:0]           ovf_vec;
  logic signed [DATA_W-1:0]  slot_arr [N_CH];

  logic [IDX_W-1:0]          gnt_idx;
  logic                      gnt_any;
  logic                      grant_go;
  logic [N_CH-1:0]           grant_clr;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (pend_vec),
    .ptr     (rr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign grant_go = (state_q == S_IDLE) && gnt_any;

  always_comb begin
    grant_clr = '0;
    if (grant_go) grant_clr[gnt_idx] = 1'b1;
  end

  // Per-channel holding slot. The pending bit is cleared on the edge that
  // enters LOAD, so a strobe during LOAD refills the slot without overflow.
  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    logic                      slot_pend_q;
    logic                      slot_ovf_q;
    logic signed [DATA_W-1:0]  slot_data_q;
    logic                      valid_k;
    logic                      accept_k;

    assign valid_k  = bus.ch_valid[k];
    assign accept_k = !slot_pend_q || OVERWRITE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        slot_pend_q <= 1'b0;
        slot_ovf_q  <= 1'b0;
        slot_data_q <= '0;
      end else begin
        if (valid_k && accept_k) slot_data_q <= bus.ch_data[k*DATA_W +: DATA_W];

        // A sample overflowing into the slot being granted survives only when
        // overwriting is enabled; otherwise it is dropped along with the grant.
        if (grant_clr[k])  slot_pend_q <= valid_k && accept_k;
        else if (valid_k)  slot_pend_q <= 1'b1;

        if (valid_k && slot_pend_q) slot_ovf_q <= 1'b1;
        else if (ovf_clr)           slot_ovf_q <= 1'b0;
      end
    end

    assign pend_vec[k] = slot_pend_q;
    assign ovf_vec[k]  = slot_ovf_q;
    assign slot_arr[k] = slot_data_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= RR_RESET;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_flag_q <= 1'b0;
      tx_ch_q   <= 3'd0;
      busy_q    <= 1'b0;
    end else begin
      tx_flag_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            state_q   <= S_LOAD;
            tx_flag_q <= 1'b1;
            tx_data_q <= slot_arr[gnt_idx];
            tx_ch_q   <= 3'(gnt_idx);
            busy_q    <= 1'b1;
            rr_q      <= gnt_idx;
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_LOAD;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_flag = tx_flag_q;
  assign bus.tx_ch   = tx_ch_q;
  assign busy        = busy_q;
  assign ovf_flag    = ovf_vec;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched: timeline model of frame starts plus directed
// scenarios with literal expectations.
module tb_uart_frame_sched;
  import uart_sched_pkg::*;

  localparam int N_CH = 4;
  localparam int FC   = 916;   // (1e6/1e5)*90 + 16

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       ovf_clr   = 1'b0;
  logic       busy;
  logic [3:0] ovf_flag;

  uart_frame_sched_if #(.N_CH(N_CH)) bus ();

  uart_frame_sched #(
    .N_CH       (N_CH),
    .CLK_FREQ   (1_000_000),
    .UART_BPS   (100_000),
    .FRAME_BITS (90),
    .GAP_CYCLES (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .ovf_flag  (ovf_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int total  = 0;
  int passed = 0;
  int printed = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else if (printed < 60) begin
      printed++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame started at cycle m_load occupies cycles m_load..m_load+FC;
  // a new grant may be decided in any later cycle while something is pending.
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_ovf  = '0;
  logic [63:0] m_slot [4];
  logic [63:0] m_data = '0;
  logic [2:0]  m_ch   = '0;
  int          m_rr   = N_CH - 1;
  int          m_load = -100000;
  logic [3:0]  pend_now;
  logic [3:0]  v;
  int          g;
  int          cand;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pend = '0; m_ovf = '0; m_data = '0; m_ch = '0;
      m_rr = N_CH - 1; m_load = -100000;
      for (int k = 0; k < N_CH; k++) m_slot[k] = '0;
    end else begin
      pend_now = m_pend;
      v = bus.ch_valid;
      if (cyc >= m_load + FC + 1 && m_pend != 0) begin
        g = -1;
        for (int i = 1; i <= N_CH; i++) begin
          cand = (m_rr + i) % N_CH;
          if (g < 0 && m_pend[cand]) g = cand;
        end
        m_load = cyc + 1;
        m_data = m_slot[g];
        m_ch   = 3'(g);
        m_rr   = g;
        m_pend[g] = 1'b0;
      end
      if (ovf_clr) m_ovf = '0;
      for (int k = 0; k < N_CH; k++) begin
        if (v[k]) begin
          if (pend_now[k]) begin
            m_ovf[k] = 1'b1;
`ifdef UART_SCHED_OVERWRITE_EN
            m_slot[k] = bus.ch_data[k*64 +: 64];
            m_pend[k] = 1'b1;
`endif
          end else begin
            m_slot[k] = bus.ch_data[k*64 +: 64];
            m_pend[k] = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  int          fl_cyc  [$];
  logic [2:0]  fl_ch   [$];
  logic [63:0] fl_data [$];
  int          busy_fall = -1;
  logic        busy_prev = 1'b0;

  always @(negedge sys_clk) begin
    chk("tx_flag", 64'(bus.tx_flag), 64'(cyc == m_load));
    chk("busy", 64'(busy), 64'(cyc >= m_load && cyc <= m_load + FC));
    chk("tx_data", bus.tx_data, m_data);
    chk("tx_ch", 64'(bus.tx_ch), 64'(m_ch));
    chk("ovf_flag", 64'(ovf_flag), 64'(m_ovf));
    if (bus.tx_flag === 1'b1) begin
      fl_cyc.push_back(cyc);
      fl_ch.push_back(bus.tx_ch);
      fl_data.push_back(bus.tx_data);
    end
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [63:0] d);
    bus.ch_data[k*64 +: 64] = d;
  endtask

  task automatic pulse(input logic [3:0] vv);
    bus.ch_valid = vv;
    step(1);
    bus.ch_valid = '0;
  endtask

  task automatic clear_log();
    fl_cyc.delete(); fl_ch.delete(); fl_data.delete();
    busy_fall = -1;
  endtask

  task automatic do_reset();
    bus.ch_valid = '0;
    ovf_clr = 1'b0;
    sys_rst_n = 1'b0;
    step(3);
    sys_rst_n = 1'b1;
    step(2);
    clear_log();
  endtask

  task automatic wait_flags(input int n, input int budget);
    int b = 0;
    while (fl_cyc.size() < n && b < budget) begin step(1); b++; end
    if (fl_cyc.size() < n) begin
      total++;
      $display("FAIL wait_flags: saw %0d frame starts, required %0d", fl_cyc.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while (busy_fall < 0 && b < budget) begin step(1); b++; end
    if (busy_fall < 0) begin
      total++;
      $display("FAIL wait_idle: busy still %b, required 0", busy);
    end
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_0003;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_0005;
  localparam logic [63:0] C = 64'hCCCC_CCCC_0000_0004;
  localparam logic [63:0] E = 64'h0000_0000_0000_00E0;
  localparam logic [63:0] G = 64'hF000_0000_0000_00F1;
  logic [63:0] s2d [4];
  int c0;
  int L;

  initial begin
    bus.ch_valid = '0;
    bus.ch_data  = '0;
    s2d[0] = 64'h0000_0000_0000_0A00;
    s2d[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    s2d[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    s2d[3] = 64'h8000_0000_0000_0000;

    // 1: single request on ch1
    do_reset();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tx_data", bus.tx_data, 64'd0);
    set_data(1, 64'h8000_0000_0000_0001);
    c0 = cyc;
    pulse(4'b0010);
    wait_flags(1, 10);
    if (fl_cyc.size() >= 1) begin
      chk("s1_start", 64'(fl_cyc[0]), 64'(c0 + 2));
      chk("s1_ch", 64'(fl_ch[0]), 64'd1);
      chk("s1_data", fl_data[0], 64'h8000_0000_0000_0001);
    end
    wait_idle(1000);
    chk("s1_busy_fall", 64'(busy_fall), 64'(c0 + 2 + 917));

    // 2: all four at once, granted 0..3 with 918-cycle spacing
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, s2d[k]);
    c0 = cyc;
    pulse(4'b1111);
    wait_flags(4, 4000);
    if (fl_cyc.size() >= 4) begin
      chk("s2_first", 64'(fl_cyc[0]), 64'(c0 + 2));
      for (int i = 0; i < 4; i++) begin
        chk("s2_ch", 64'(fl_ch[i]), 64'(i));
        chk("s2_data", fl_data[i], s2d[i]);
        if (i > 0) chk("s2_spacing", 64'(fl_cyc[i] - fl_cyc[i-1]), 64'd918);
      end
    end
    chk("s2_ovf", 64'(ovf_flag), 64'd0);

    // 3: ch2 twice during another channel's frame
    do_reset();
    set_data(0, 64'h1);
    pulse(4'b0001);
    step(10);
    set_data(2, A);
    pulse(4'b0100);
    step(5);
    set_data(2, B);
    pulse(4'b0100);
    step(1);
    chk("s3_ovf", 64'(ovf_flag), 64'h4);
    wait_flags(2, 2000);
    if (fl_cyc.size() >= 2) begin
      chk("s3_ch", 64'(fl_ch[1]), 64'd2);
`ifdef UART_SCHED_OVERWRITE_EN
      chk("s3_data", fl_data[1], B);
`else
      chk("s3_data", fl_data[1], A);
`endif
    end

    // 4: ch0 refilled in its own LOAD cycle
    do_reset();
    set_data(0, 64'h0000_0000_0000_0C01);
    c0 = cyc;
    pulse(4'b0001);
    step(1);
    set_data(0, C);
    pulse(4'b0001);
    chk("s4_ovf", 64'(ovf_flag), 64'd0);
    wait_flags(2, 2000);
    if (fl_cyc.size() >= 2) begin
      chk("s4_first", 64'(fl_cyc[0]), 64'(c0 + 2));
      chk("s4_ch", 64'(fl_ch[1]), 64'd0);
      chk("s4_data", fl_data[1], C);
      chk("s4_start", 64'(fl_cyc[1]), 64'(c0 + 2 + 918));
    end

    // 5: reset 300 cycles into WAIT, then a fresh request
    do_reset();
    set_data(1, 64'h1234_5678_9ABC_DEF0);
    pulse(4'b0010);
    wait_flags(1, 10);
    L = (fl_cyc.size() >= 1) ? fl_cyc[0] : cyc;
    while (cyc < L + 300) step(1);
    sys_rst_n = 1'b0;
    #2;
    chk("s5_rst_flag", 64'(bus.tx_flag), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_data", bus.tx_data, 64'd0);
    chk("s5_rst_ch", 64'(bus.tx_ch), 64'd0);
    step(2);
    sys_rst_n = 1'b1;
    step(2);
    clear_log();
    set_data(3, 64'hFEDC_0000_0000_0033);
    c0 = cyc;
    pulse(4'b1000);
    wait_flags(1, 10);
    if (fl_cyc.size() >= 1) begin
      chk("s5_start", 64'(fl_cyc[0]), 64'(c0 + 2));
      chk("s5_ch", 64'(fl_ch[0]), 64'd3);
      chk("s5_data", fl_data[0], 64'hFEDC_0000_0000_0033);
    end

    // 6: ovf_clr coincident with a new overflow on ch3
    do_reset();
    set_data(0, 64'h5);
    pulse(4'b0001);
    step(4);
    set_data(3, E);
    pulse(4'b1000);
    step(2);
    set_data(3, 64'h0000_0000_0000_00E1);
    pulse(4'b1000);
    step(1);
    chk("s6_ovf_set", 64'(ovf_flag), 64'h8);
    set_data(3, G);
    ovf_clr = 1'b1;
    pulse(4'b1000);
    ovf_clr = 1'b0;
    chk("s6_set_wins", 64'(ovf_flag), 64'h8);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("s6_cleared", 64'(ovf_flag), 64'd0);
    wait_flags(2, 2000);
    if (fl_cyc.size() >= 2) begin
      chk("s6_ch", 64'(fl_ch[1]), 64'd3);
`ifdef UART_SCHED_OVERWRITE_EN
      chk("s6_data", fl_data[1], G);
`else
      chk("s6_data", fl_data[1], E);
`endif
    end

    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
